// File: rtl/clock_divider_prog.sv
// Runtime-programmable divider of in_clk: pulse, square or duty-cycle enable,
// a one-cycle tick per period and the live phase counter, all in the in_clk domain.
module clock_divider_prog #(
    parameter int WIDTH        = 17,
    parameter int DEFAULT_DIV  = 100000,
    parameter int DEFAULT_MODE = 1
) (
    input  logic             in_clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             restart,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic [1:0]       mode_in,
    input  logic [WIDTH-1:0] high_in,
    output logic             out_clk,
    output logic             tick,
    output logic [WIDTH-1:0] count,
    output logic             pending
);

    typedef enum logic [1:0] {
        MODE_PULSE  = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_DUTY   = 2'd2
    } mode_t;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);
    localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] RST_HIGH = RST_DIV >> 1;
    localparam mode_t            RST_MODE = mode_t'(2'(DEFAULT_MODE));

    logic [WIDTH-1:0] act_n;
    logic [WIDTH-1:0] act_h;
    mode_t            act_mode;
    logic [WIDTH-1:0] shd_n;
    logic [WIDTH-1:0] shd_h;
    mode_t            shd_mode;
    logic [WIDTH-1:0] ld_n;
    logic [WIDTH-1:0] ld_h;
    mode_t            ld_mode;
    logic [WIDTH-1:0] last;
    logic             at_wrap;
    logic             next_out;

    always_comb begin
        ld_n    = (div_in < TWO) ? TWO : div_in;
        ld_h    = (high_in > ld_n) ? ld_n : high_in;
        ld_mode = (mode_in == 2'd3) ? MODE_SQUARE : mode_t'(mode_in);
    end

    // A counter left above the new period after reconfiguration wraps on its next step.
    assign last    = act_n - ONE;
    assign at_wrap = (count >= last);

    always_comb begin
        case (act_mode)
            MODE_PULSE: next_out = (count == last);
            MODE_DUTY:  next_out = (count >= act_n - act_h);
            default:    next_out = (count >= act_n - (act_n >> 1));
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (reset) begin
            count    <= '0;
            out_clk  <= 1'b0;
            tick     <= 1'b0;
            pending  <= 1'b0;
            act_n    <= RST_DIV;
            act_h    <= RST_HIGH;
            act_mode <= RST_MODE;
            shd_n    <= RST_DIV;
            shd_h    <= RST_HIGH;
            shd_mode <= RST_MODE;
        end else if (restart) begin
            count   <= '0;
            out_clk <= 1'b0;
            tick    <= 1'b0;
            pending <= 1'b0;
            if (load) begin
                act_n    <= ld_n;
                act_h    <= ld_h;
                act_mode <= ld_mode;
            end else if (pending) begin
                act_n    <= shd_n;
                act_h    <= shd_h;
                act_mode <= shd_mode;
            end
        end else begin
            if (load) begin
                shd_n    <= ld_n;
                shd_h    <= ld_h;
                shd_mode <= ld_mode;
                pending  <= 1'b1;
            end
            if (enable) begin
                out_clk <= next_out;
                if (at_wrap) begin
                    count <= '0;
                    tick  <= 1'b1;
                    // A load landing on the wrap goes live directly, bypassing the shadow.
                    if (load) begin
                        act_n    <= ld_n;
                        act_h    <= ld_h;
                        act_mode <= ld_mode;
                        pending  <= 1'b0;
                    end else if (pending) begin
                        act_n    <= shd_n;
                        act_h    <= shd_h;
                        act_mode <= shd_mode;
                        pending  <= 1'b0;
                    end
                end else begin
                    count <= count + ONE;
                    tick  <= 1'b0;
                end
            end else begin
                tick <= 1'b0;
            end
        end
    end

endmodule
